conv_ibuf: RTL and testbench

Streaming line buffer that builds convolution windows for `conv_ctrl`. It accepts a raster-ordered, channel-interleaved feature map one element per cycle and holds the last `kernel_dim-1` rows plus `kernel_dim` pixels. Each time a complete `kernel_dim x kernel_dim x input_channels` window (stride 1, no padding) is present, it freezes, presents the window on `o_data` and raises `o_start`. It waits for `conv_ctrl` to consume the window, then resumes.

---
 rtl/conv_ibuf.sv | 142 ++++++++++++++
 tb/tb_conv_ibuf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ibuf.sv
// Streaming line buffer that freezes and presents each K x K x C convolution window to conv_ctrl.
// Optional CONV_IBUF_STATS_EN adds o_window_count, a free-running count of acknowledged windows.
module conv_ibuf #(
  parameter int unsigned datatype_size  = 8,
  parameter int unsigned input_channels = 5,
  parameter int unsigned kernel_dim     = 3,
  parameter int unsigned image_width    = 8,
  parameter int unsigned image_height   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [datatype_size-1:0] i_data,
  output logic                     o_ready,
  output logic                     o_start,
  input  logic                     i_ctrl_busy,
  output logic [datatype_size-1:0] o_data [input_channels*kernel_dim*kernel_dim],
  output logic                     o_frame_done
`ifdef CONV_IBUF_STATS_EN
  ,
  output logic [31:0]              o_window_count
`endif
);

  localparam int unsigned input_size = input_channels * kernel_dim * kernel_dim;
  localparam int unsigned buf_depth  =
      ((kernel_dim - 1) * image_width + kernel_dim) * input_channels;
  localparam int unsigned ChW  = (input_channels > 1) ? $clog2(input_channels) : 1;
  localparam int unsigned ColW = (image_width > 1) ? $clog2(image_width) : 1;
  localparam int unsigned RowW = (image_height > 1) ? $clog2(image_height) : 1;

  typedef enum logic [1:0] {StFill, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  logic [datatype_size-1:0] sr_q [buf_depth];
  logic [ChW-1:0]           ch_q;
  logic [ColW-1:0]          col_q;
  logic [RowW-1:0]          row_q;
  logic ready_q, start_q, frame_done_q, last_q;
  logic ready_d, start_d, frame_done_d;
  logic accept, ch_max, col_max, row_max, win_done;

  assign accept   = i_valid & ready_q;
  assign ch_max   = (ch_q == ChW'(input_channels - 1));
  assign col_max  = (col_q == ColW'(image_width - 1));
  assign row_max  = (row_q == RowW'(image_height - 1));
  assign win_done = ch_max && (col_q >= ColW'(kernel_dim - 1)) &&
                    (row_q >= RowW'(kernel_dim - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(buf_depth); i++) sr_q[i] <= '0;
    end else if (accept) begin
      sr_q[0] <= i_data;
      for (int i = 1; i < int'(buf_depth); i++) sr_q[i] <= sr_q[i-1];
    end
  end

  // Raster position of the element being accepted: channel fastest, then column, then row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (ch_max) begin
        ch_q <= '0;
        if (col_max) begin
          col_q <= '0;
          row_q <= row_max ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else begin
        ch_q <= ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFill;
      ready_q      <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      if (state_q == StFill && accept && win_done) last_q <= ch_max && col_max && row_max;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (accept && win_done) state_d = StIssue;
      StIssue: if (i_ctrl_busy) state_d = StDrain;
      StDrain: if (!i_ctrl_busy) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    ready_d      = (state_d == StFill);
    start_d      = (state_d == StIssue);
    frame_done_d = (state_q == StDrain) && !i_ctrl_busy && last_q;
  end

  assign o_ready      = ready_q;
  assign o_start      = start_q;
  assign o_frame_done = frame_done_q;

  // ky = 0 is the oldest (top) row of the window, so it sits deepest in the shift register.
  for (genvar ky = 0; ky < int'(kernel_dim); ky++) begin : g_ky
    for (genvar kx = 0; kx < int'(kernel_dim); kx++) begin : g_kx
      for (genvar c = 0; c < int'(input_channels); c++) begin : g_c
        assign o_data[(ky * kernel_dim + kx) * input_channels + c] =
            sr_q[((kernel_dim - 1 - ky) * image_width + (kernel_dim - 1 - kx)) * input_channels
                 + (input_channels - 1 - c)];
      end
    end
  end

`ifdef CONV_IBUF_STATS_EN
  logic [31:0] window_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_count_q <= '0;
    end else if (state_q == StIssue && i_ctrl_busy) begin
      window_count_q <= window_count_q + 32'd1;
    end
  end

  assign o_window_count = window_count_q;
`endif

endmodule

// File: tb/tb_conv_ibuf.sv
// Bench for conv_ibuf: window contents and issue positions checked against an image-array model.
module tb_conv_ibuf;
  localparam int AK  = 3;
  localparam int AW  = 4;
  localparam int AH  = 4;
  localparam int AN  = AK * AK;
  localparam int AWX = AW - AK + 1;
  localparam int AWY = AH - AK + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid = 1'b0;
  logic [7:0] a_data  = '0;
  logic       a_busy  = 1'b0;
  logic       a_ready, a_start, a_fd;
  logic [7:0] a_win [AN];
  logic       b_valid = 1'b0;
  logic [7:0] b_data  = '0;
  logic       b_busy  = 1'b0;
  logic       b_ready, b_start, b_fd;
  logic [7:0] b_win [8];
`ifdef CONV_IBUF_STATS_EN
  logic [31:0] a_wcnt, b_wcnt;
`endif

  conv_ibuf #(
    .datatype_size(8), .input_channels(1), .kernel_dim(AK), .image_width(AW), .image_height(AH)
  ) u_dut_a (
    .clk(clk), .rst(rst_n), .i_valid(a_valid), .i_data(a_data), .o_ready(a_ready),
    .o_start(a_start), .i_ctrl_busy(a_busy), .o_data(a_win), .o_frame_done(a_fd)
`ifdef CONV_IBUF_STATS_EN
    , .o_window_count(a_wcnt)
`endif
  );

  conv_ibuf #(
    .datatype_size(8), .input_channels(2), .kernel_dim(2), .image_width(2), .image_height(2)
  ) u_dut_b (
    .clk(clk), .rst(rst_n), .i_valid(b_valid), .i_data(b_data), .o_ready(b_ready),
    .o_start(b_start), .i_ctrl_busy(b_busy), .o_data(b_win), .o_frame_done(b_fd)
`ifdef CONV_IBUF_STATS_EN
    , .o_window_count(b_wcnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: the current image as accepted, and where the stream stands within it.
  logic [7:0] img [AW*AH];
  int acc_cnt = 0;
  int win_in_img = 0;
  int acked = 0;
  int fd_cnt = 0;
  int phase = 0;
  int hold = 0;
  int busy_hold = 0;
  bit no_ack = 1'b0;
  bit lit_img = 1'b0;
  logic [7:0] snap [AN];
  int first_lit [AN] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int last_lit  [AN] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int b_starts = 0;
  int b_fd_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_window();
    int wy, wx;
    wy = win_in_img / AWX;
    wx = win_in_img % AWX;
    check("a_win_pos", acc_cnt, (wy + AK - 1) * AW + wx + AK);
    for (int ky = 0; ky < AK; ky++)
      for (int kx = 0; kx < AK; kx++)
        check("a_win_data", int'(a_win[ky*AK+kx]), int'(img[(wy+ky)*AW + wx + kx]));
    if (lit_img && win_in_img == 0)
      for (int i = 0; i < AN; i++) check("a_win_first_lit", int'(a_win[i]), first_lit[i]);
    if (lit_img && win_in_img == AWX * AWY - 1)
      for (int i = 0; i < AN; i++) check("a_win_last_lit", int'(a_win[i]), last_lit[i]);
    win_in_img = (win_in_img + 1) % (AWX * AWY);
  endtask

  // Compare process for instance A; also plays conv_ctrl (busy raised on start, held busy_hold).
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        phase  = 0;
        a_busy = 1'b0;
        continue;
      end
      case (phase)
        0: begin
          check("a_fd_idle", int'(a_fd), 0);
          if (a_start) begin
            check_window();
            if (no_ack) begin
              phase = 3;
            end else begin
              a_busy = 1'b1;
              hold   = busy_hold;
              snap   = a_win;
              phase  = 1;
            end
          end
        end
        1: begin
          check("a_start_drop", int'(a_start), 0);
          check("a_ready_drain", int'(a_ready), 0);
          for (int i = 0; i < AN; i++) check("a_data_frozen", int'(a_win[i]), int'(snap[i]));
          if (hold == 0) begin
            a_busy = 1'b0;
            phase  = 2;
          end else begin
            hold--;
          end
        end
        2: begin
          check("a_ready_resume", int'(a_ready), 1);
          check("a_frame_done", int'(a_fd), int'(win_in_img == 0));
          acked++;
          if (a_fd) fd_cnt++;
          phase = 0;
        end
        default: ;
      endcase
    end
  end

  // Instance B: combinational-style acknowledge and window check against {0..7}.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      b_busy = b_start && rst_n;
      if (rst_n && b_start) begin
        b_starts++;
        for (int i = 0; i < 8; i++) check("b_win_data", int'(b_win[i]), i);
      end
      if (rst_n && b_fd) b_fd_cnt++;
    end
  end

  task automatic push_a(input int idx, input int v);
    int t = 0;
    a_valid = 1'b1;
    a_data  = 8'(v);
    while (!a_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("a_accept", int'(a_ready), 1);
    @(negedge clk);
    img[idx] = 8'(v);
    acc_cnt  = idx + 1;
    a_valid  = 1'b0;
  endtask

  task automatic push_b(input int v);
    int t = 0;
    b_valid = 1'b1;
    b_data  = 8'(v);
    while (!b_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("b_accept", int'(b_ready), 1);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic send_image_a(input int base, input int max_gap);
    for (int i = 0; i < AW * AH; i++) begin
      push_a(i, base + i);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((phase != 0 || !a_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("a_idle_timeout", int'(t < 200), 1);
  endtask

  initial begin
    #1;
    check("rst_a_ready", int'(a_ready), 0);
    check("rst_a_start", int'(a_start), 0);
    check("rst_a_fd", int'(a_fd), 0);
    check("rst_a_data0", int'(a_win[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("a_ready_after_rst", int'(a_ready), 1);

    // Elements 0..15, single-cycle acknowledge.
    lit_img = 1'b1;
    send_image_a(0, 0);
    wait_idle();
    lit_img = 1'b0;
    check("a_fd_count_img1", fd_cnt, 1);
    check("a_windows_img1", acked, 4);

    // Long DRAIN: busy held 20 extra cycles per window.
    busy_hold = 20;
    send_image_a(32, 0);
    wait_idle();
    busy_hold = 0;
    check("a_fd_count_img2", fd_cnt, 2);
`ifdef CONV_IBUF_STATS_EN
    check("a_window_count_2img", int'(a_wcnt), 8);
`endif

    // Random gaps, back-to-back images.
    send_image_a(64, 3);
    send_image_a(100, 2);
    wait_idle();
    check("a_fd_count_img4", fd_cnt, 4);
`ifdef CONV_IBUF_STATS_EN
    check("a_window_count_4img", int'(a_wcnt), acked);
`endif

    // Reset while a window sits in ISSUE.
    no_ack = 1'b1;
    for (int i = 0; i < (AK - 1) * AW + AK; i++) push_a(i, 200 + i);
    @(negedge clk);
    check("a_start_before_rst", int'(a_start), 1);
    rst_n = 1'b0;
    #1;
    check("a_start_in_rst", int'(a_start), 0);
    check("a_ready_in_rst", int'(a_ready), 0);
    check("a_fd_in_rst", int'(a_fd), 0);
    no_ack     = 1'b0;
    win_in_img = 0;
    acc_cnt    = 0;
    acked      = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_image_a(150, 0);
    wait_idle();
    check("a_fd_count_after_rst", fd_cnt, 5);
`ifdef CONV_IBUF_STATS_EN
    check("a_window_count_after_rst", int'(a_wcnt), 4);
`endif

    // C=2, K=2, W=H=2: exactly one window {0..7}.
    for (int i = 0; i < 8; i++) push_b(i);
    repeat (6) @(negedge clk);
    check("b_window_count", b_starts, 1);
    check("b_fd_count", b_fd_cnt, 1);
    check("b_ready_end", int'(b_ready), 1);
`ifdef CONV_IBUF_STATS_EN
    check("b_window_stat", int'(b_wcnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
